// File: rtl/uart_mmio_pkg.sv
// Shared types and bit positions for the UART MMIO controller.
package uart_mmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } tx_state_t;

  // rx_ready status word bit positions
  localparam int RX_VALID_BIT = 0;
  localparam int OVERRUN_BIT  = 1;
  localparam int TX_BUSY_BIT  = 2;
  localparam int TX_DONE_BIT  = 3;

  // command register bit positions
  localparam int CMD_SEND_BIT    = 0;  // tx register
  localparam int CMD_POP_BIT     = 0;  // clean_rx register
  localparam int CMD_CLR_OVR_BIT = 1;  // clean_rx register

endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// Register-side and UART-side signals of the UART MMIO controller.
// slave = controller view, master = core/serdes environment view.
interface uart_mmio_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tx_i;
  logic [DATA_WIDTH-1:0] tx_data_i;
  logic [DATA_WIDTH-1:0] clean_rx_i;
  logic [DATA_WIDTH-1:0] rx_ready_o;
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic                  uart_tx_valid_o;
  logic [7:0]            uart_tx_data_o;
  logic                  uart_tx_ready_i;
  logic                  uart_rx_valid_i;
  logic [7:0]            uart_rx_data_i;

  modport slave (
    input  tx_i, tx_data_i, clean_rx_i, uart_tx_ready_i, uart_rx_valid_i, uart_rx_data_i,
    output rx_ready_o, rx_data_o, uart_tx_valid_o, uart_tx_data_o
  );

  modport master (
    output tx_i, tx_data_i, clean_rx_i, uart_tx_ready_i, uart_rx_valid_i, uart_rx_data_i,
    input  rx_ready_o, rx_data_o, uart_tx_valid_o, uart_tx_data_o
  );
endinterface

// File: rtl/rx_byte_fifo.sv
// Small byte FIFO for received UART data with a sticky overrun flag.
// A push while full is accepted only if a pop happens in the same cycle.
module rx_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       clr_ovr,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] head,
  output logic       overrun
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          ovr_q;
  logic          do_push, do_pop, ovr_set;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovr_set = push & full & ~do_pop;
  assign head    = empty ? 8'h00 : mem[rd_ptr];
  assign overrun = ovr_q;

  // pointers, occupancy and sticky overrun (set beats clear)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
      if (ovr_set)      ovr_q <= 1'b1;
      else if (clr_ovr) ovr_q <= 1'b0;
    end
  end

  // storage; contents are don't-care while empty since head is gated
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// UART MMIO controller: TX level-protocol FSM, clean_rx edge detectors,
// RX FIFO and status word assembly.
// Optional macro UART_MMIO_LOOPBACK_EN routes sent bytes into the RX FIFO.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RX_DEPTH   = 4
) (
  input logic             clk,
  input logic             reset,
  uart_mmio_ctrl_if.slave bus
);
  tx_state_t  state, state_nxt;
  logic [7:0] tx_byte;
  logic [1:0] clean_q;
  logic       pop_edge, clr_edge;
  logic       fifo_push, fifo_full, fifo_empty, fifo_ovr;
  logic [7:0] fifo_din, fifo_head;
  logic       unused_bits;

  assign pop_edge = bus.clean_rx_i[CMD_POP_BIT] & ~clean_q[0];
  assign clr_edge = bus.clean_rx_i[CMD_CLR_OVR_BIT] & ~clean_q[1];

  // TX next state; a byte is sent once per 0->1->0 of the send bit
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.tx_i[CMD_SEND_BIT]) state_nxt = SEND;
`ifdef UART_MMIO_LOOPBACK_EN
      SEND: state_nxt = HOLD;
`else
      SEND: if (bus.uart_tx_ready_i) state_nxt = HOLD;
`endif
      HOLD: if (!bus.tx_i[CMD_SEND_BIT]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // TX state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // byte latch on IDLE->SEND, and previous clean_rx bits for edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_byte <= 8'h00;
      clean_q <= 2'b00;
    end else begin
      if (state == IDLE && bus.tx_i[CMD_SEND_BIT]) tx_byte <= bus.tx_data_i[7:0];
      clean_q <= {bus.clean_rx_i[CMD_CLR_OVR_BIT], bus.clean_rx_i[CMD_POP_BIT]};
    end
  end

`ifdef UART_MMIO_LOOPBACK_EN
  // SEND lasts exactly one cycle, so the byte is pushed once
  assign fifo_push           = (state == SEND);
  assign fifo_din            = tx_byte;
  assign bus.uart_tx_valid_o = 1'b0;
  assign unused_bits = ^{bus.tx_i[DATA_WIDTH-1:1], bus.tx_data_i[DATA_WIDTH-1:8],
                         bus.clean_rx_i[DATA_WIDTH-1:2], bus.uart_tx_ready_i,
                         bus.uart_rx_valid_i, bus.uart_rx_data_i};
`else
  assign fifo_push           = bus.uart_rx_valid_i;
  assign fifo_din            = bus.uart_rx_data_i;
  assign bus.uart_tx_valid_o = (state == SEND);
  assign unused_bits = ^{bus.tx_i[DATA_WIDTH-1:1], bus.tx_data_i[DATA_WIDTH-1:8],
                         bus.clean_rx_i[DATA_WIDTH-1:2]};
`endif

  assign bus.uart_tx_data_o = tx_byte;

  rx_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (pop_edge),
    .clr_ovr (clr_edge),
    .din     (fifo_din),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head),
    .overrun (fifo_ovr)
  );

  // status word and zero-extended head byte
  always_comb begin
    bus.rx_ready_o              = '0;
    bus.rx_ready_o[RX_VALID_BIT] = ~fifo_empty;
    bus.rx_ready_o[OVERRUN_BIT]  = fifo_ovr;
    bus.rx_ready_o[TX_BUSY_BIT]  = (state == SEND);
    bus.rx_ready_o[TX_DONE_BIT]  = (state == HOLD);
    bus.rx_data_o               = {{(DATA_WIDTH-8){1'b0}}, fifo_head};
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed self-checking bench for uart_mmio_ctrl (RX_DEPTH=4).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_uart_mmio_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   xfers = 0;

  uart_mmio_ctrl_if #(.DATA_WIDTH(32)) bus ();

  uart_mmio_ctrl #(.DATA_WIDTH(32), .RX_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // count completed valid&ready handshakes
  always @(posedge clk) begin
    if (bus.uart_tx_valid_o === 1'b1 && bus.uart_tx_ready_i === 1'b1) xfers <= xfers + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_pulse();
    bus.clean_rx_i = 32'h1;
    tick(1);
    bus.clean_rx_i = 32'h0;
    tick(1);
  endtask

  task automatic test_reset();
    tick(2);
    checks++;
    if (bus.rx_ready_o !== 32'h0 || bus.rx_data_o !== 32'h0 ||
        bus.uart_tx_valid_o !== 1'b0 || bus.uart_tx_data_o !== 8'h00)
      $display("FAIL reset_outputs: rx_ready=%h rx_data=%h valid=%b data=%h, want all 0",
               bus.rx_ready_o, bus.rx_data_o, bus.uart_tx_valid_o, bus.uart_tx_data_o);
    else passed++;
    reset = 1'b1;
    tick(1);
    checks++;
    if (bus.rx_ready_o !== 32'h0 || bus.uart_tx_valid_o !== 1'b0)
      $display("FAIL post_reset_idle: rx_ready=%h valid=%b, want 0/0", bus.rx_ready_o, bus.uart_tx_valid_o);
    else passed++;
  endtask

  task automatic test_tx();
    int x0;
    x0 = xfers;
    bus.tx_data_i = 32'h41;
    bus.tx_i = 32'h1;
    bus.uart_tx_ready_i = 1'b0;
    checks++;
    if (bus.uart_tx_valid_o !== 1'b0)
      $display("FAIL tx_valid_before_edge: got %b want 0", bus.uart_tx_valid_o);
    else passed++;
    tick(1);
    checks++;
    if (bus.uart_tx_valid_o !== 1'b1 || bus.uart_tx_data_o !== 8'h41 || bus.rx_ready_o !== 32'h4)
      $display("FAIL tx_send_state: valid=%b data=%h status=%h, want 1/41/4",
               bus.uart_tx_valid_o, bus.uart_tx_data_o, bus.rx_ready_o);
    else passed++;
    bus.tx_data_i = 32'h99;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++;
      if (bus.uart_tx_valid_o !== 1'b1 || bus.uart_tx_data_o !== 8'h41)
        $display("FAIL tx_wait_%0d: valid=%b data=%h, want 1/41", i, bus.uart_tx_valid_o, bus.uart_tx_data_o);
      else passed++;
    end
    bus.uart_tx_ready_i = 1'b1;
    tick(1);
    checks++;
    if (bus.uart_tx_valid_o !== 1'b0 || bus.rx_ready_o !== 32'h8 || (xfers - x0) != 1)
      $display("FAIL tx_hold: valid=%b status=%h xfers=%0d, want 0/8/1",
               bus.uart_tx_valid_o, bus.rx_ready_o, xfers - x0);
    else passed++;
    tick(20);
    checks++;
    if ((xfers - x0) != 1 || bus.rx_ready_o !== 32'h8)
      $display("FAIL tx_resend_guard: xfers=%0d status=%h, want 1/8", xfers - x0, bus.rx_ready_o);
    else passed++;
    bus.tx_i = 32'h0;
    bus.uart_tx_ready_i = 1'b0;
    tick(1);
    checks++;
    if (bus.rx_ready_o !== 32'h0 || bus.uart_tx_valid_o !== 1'b0)
      $display("FAIL tx_back_to_idle: status=%h valid=%b, want 0/0", bus.rx_ready_o, bus.uart_tx_valid_o);
    else passed++;
  endtask

  task automatic test_rx_order();
    bus.uart_rx_valid_i = 1'b1;
    bus.uart_rx_data_i = 8'h10;
    tick(1);
    checks++;
    if (bus.rx_data_o !== 32'h10 || bus.rx_ready_o !== 32'h1)
      $display("FAIL rx_first_visible: data=%h status=%h, want 10/1", bus.rx_data_o, bus.rx_ready_o);
    else passed++;
    bus.uart_rx_data_i = 8'h20;
    tick(1);
    bus.uart_rx_data_i = 8'h30;
    tick(1);
    bus.uart_rx_valid_i = 1'b0;
    tick(1);
    pop_pulse();
    checks++;
    if (bus.rx_data_o !== 32'h20 || bus.rx_ready_o !== 32'h1)
      $display("FAIL rx_pop1: data=%h status=%h, want 20/1", bus.rx_data_o, bus.rx_ready_o);
    else passed++;
    pop_pulse();
    checks++;
    if (bus.rx_data_o !== 32'h30)
      $display("FAIL rx_pop2: data=%h want 30", bus.rx_data_o);
    else passed++;
    pop_pulse();
    checks++;
    if (bus.rx_data_o !== 32'h0 || bus.rx_ready_o !== 32'h0)
      $display("FAIL rx_pop3_empty: data=%h status=%h, want 0/0", bus.rx_data_o, bus.rx_ready_o);
    else passed++;
    pop_pulse();
    checks++;
    if (bus.rx_ready_o !== 32'h0)
      $display("FAIL rx_pop_when_empty: status=%h want 0", bus.rx_ready_o);
    else passed++;
  endtask

  task automatic test_overrun();
    bus.uart_rx_valid_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.uart_rx_data_i = 8'hA0 + 8'(i);
      tick(1);
    end
    bus.uart_rx_valid_i = 1'b0;
    tick(1);
    checks++;
    if (bus.rx_ready_o !== 32'h3 || bus.rx_data_o !== 32'hA1)
      $display("FAIL ovr_set: status=%h data=%h, want 3/a1", bus.rx_ready_o, bus.rx_data_o);
    else passed++;
    bus.clean_rx_i = 32'h2;
    tick(1);
    bus.clean_rx_i = 32'h0;
    tick(1);
    checks++;
    if (bus.rx_ready_o !== 32'h1)
      $display("FAIL ovr_clear: status=%h want 1", bus.rx_ready_o);
    else passed++;
    bus.uart_rx_valid_i = 1'b1;
    bus.uart_rx_data_i = 8'hB0;
    bus.clean_rx_i = 32'h1;
    tick(1);
    bus.uart_rx_valid_i = 1'b0;
    bus.clean_rx_i = 32'h0;
    checks++;
    if (bus.rx_ready_o !== 32'h1 || bus.rx_data_o !== 32'hA2)
      $display("FAIL full_push_pop: status=%h data=%h, want 1/a2", bus.rx_ready_o, bus.rx_data_o);
    else passed++;
    tick(1);
    pop_pulse();
    checks++;
    if (bus.rx_data_o !== 32'hA3)
      $display("FAIL drain_a3: data=%h want a3", bus.rx_data_o);
    else passed++;
    pop_pulse();
    checks++;
    if (bus.rx_data_o !== 32'hA4)
      $display("FAIL drain_a4: data=%h want a4", bus.rx_data_o);
    else passed++;
    pop_pulse();
    checks++;
    if (bus.rx_data_o !== 32'hB0 || bus.rx_ready_o !== 32'h1)
      $display("FAIL drain_b0: data=%h status=%h, want b0/1", bus.rx_data_o, bus.rx_ready_o);
    else passed++;
    pop_pulse();
    checks++;
    if (bus.rx_ready_o !== 32'h0 || bus.rx_data_o !== 32'h0)
      $display("FAIL drain_empty: status=%h data=%h, want 0/0", bus.rx_ready_o, bus.rx_data_o);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int x0;
    x0 = xfers;
    bus.tx_data_i = 32'h77;
    bus.tx_i = 32'h1;
    bus.uart_tx_ready_i = 1'b0;
    bus.uart_rx_valid_i = 1'b1;
    bus.uart_rx_data_i = 8'h11;
    tick(1);
    bus.uart_rx_data_i = 8'h22;
    tick(1);
    bus.uart_rx_valid_i = 1'b0;
    checks++;
    if (bus.uart_tx_valid_o !== 1'b1 || bus.rx_ready_o !== 32'h5 || bus.rx_data_o !== 32'h11)
      $display("FAIL pre_reset_state: valid=%b status=%h data=%h, want 1/5/11",
               bus.uart_tx_valid_o, bus.rx_ready_o, bus.rx_data_o);
    else passed++;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.uart_tx_valid_o !== 1'b0 || bus.rx_ready_o !== 32'h0 ||
        bus.rx_data_o !== 32'h0 || bus.uart_tx_data_o !== 8'h00)
      $display("FAIL async_reset_outputs: valid=%b status=%h data=%h txd=%h, want all 0",
               bus.uart_tx_valid_o, bus.rx_ready_o, bus.rx_data_o, bus.uart_tx_data_o);
    else passed++;
    bus.tx_i = 32'h0;
    tick(2);
    reset = 1'b1;
    bus.uart_tx_ready_i = 1'b1;
    tick(2);
    checks++;
    if (bus.rx_ready_o !== 32'h0 || bus.uart_tx_valid_o !== 1'b0 || (xfers - x0) != 0)
      $display("FAIL after_release: status=%h valid=%b xfers=%0d, want 0/0/0",
               bus.rx_ready_o, bus.uart_tx_valid_o, xfers - x0);
    else passed++;
    bus.uart_tx_ready_i = 1'b0;
  endtask

  task automatic test_loopback();
    bus.tx_data_i = 32'h5A;
    bus.tx_i = 32'h1;
    tick(1);
    checks++;
    if (bus.uart_tx_valid_o !== 1'b0 || bus.rx_ready_o !== 32'h4)
      $display("FAIL lb_send: valid=%b status=%h, want 0/4", bus.uart_tx_valid_o, bus.rx_ready_o);
    else passed++;
    tick(1);
    checks++;
    if (bus.uart_tx_valid_o !== 1'b0 || bus.rx_data_o !== 32'h5A || bus.rx_ready_o !== 32'h9)
      $display("FAIL lb_pushed: valid=%b data=%h status=%h, want 0/5a/9",
               bus.uart_tx_valid_o, bus.rx_data_o, bus.rx_ready_o);
    else passed++;
    bus.tx_i = 32'h0;
    tick(1);
    checks++;
    if (bus.rx_ready_o !== 32'h1)
      $display("FAIL lb_idle: status=%h want 1", bus.rx_ready_o);
    else passed++;
    pop_pulse();
    checks++;
    if (bus.rx_ready_o !== 32'h0)
      $display("FAIL lb_pop: status=%h want 0", bus.rx_ready_o);
    else passed++;
  endtask

  initial begin
    bus.tx_i = '0;
    bus.tx_data_i = '0;
    bus.clean_rx_i = '0;
    bus.uart_tx_ready_i = 1'b0;
    bus.uart_rx_valid_i = 1'b0;
    bus.uart_rx_data_i = 8'h00;
    test_reset();
`ifdef UART_MMIO_LOOPBACK_EN
    test_loopback();
`else
    test_tx();
    test_rx_order();
    test_overrun();
    test_reset_mid();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
- Sequences the UART byte link behind the core's memory-mapped tx, tx_data, clean_rx, rx_ready and rx_data registers.
- Turns software register writes into a valid/ready transmit handshake to the UART transmitter.
- Buffers received bytes in a small FIFO and presents them through the rx_ready/rx_data read registers.
- Sits between those registers and the UART serializer/deserializer, on the core clock.

Parameters:
- DATA_WIDTH, 32, width of the MMIO register words.
- RX_DEPTH, 4, RX FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- tx_i  in  DATA_WIDTH  tx register value; bit0 is the send request level.
- tx_data_i  in  DATA_WIDTH  tx_data register value; bits[7:0] are the byte.
- clean_rx_i  in  DATA_WIDTH  clean_rx register value; bit0 pops, bit1 clears overrun.
- rx_ready_o  out  DATA_WIDTH  status word: bit0 rx_valid, bit1 overrun, bit2 tx_busy, bit3 tx_done; other bits 0.
- rx_data_o  out  DATA_WIDTH  FIFO head byte, zero-extended; 0 when empty.
- uart_tx_valid_o  out  1  byte offered to the transmitter.
- uart_tx_data_o  out  8  byte to transmit.
- uart_tx_ready_i  in  1  transmitter accepts the byte when high together with valid.
- uart_rx_valid_i  in  1  one-cycle strobe: a received byte is present.
- uart_rx_data_i  in  8  received byte.

Behaviour:
- Reset (reset=0, asynchronous):
  - TX FSM goes to IDLE, FIFO is emptied, overrun=0, edge registers=0.
  - All outputs are 0.
- TX FSM states IDLE, SEND, HOLD:
  - IDLE: when tx_i[0]=1, latch tx_data_i[7:0] into uart_tx_data_o and go to SEND. uart_tx_valid_o rises the cycle after tx_i[0] is first sampled high.
  - SEND: uart_tx_valid_o=1 and tx_busy=1. The data register stays stable. When uart_tx_ready_i=1 at a clock edge, go to HOLD; valid drops the next cycle.
  - HOLD: tx_done=1, valid=0. When tx_i[0]=0, go to IDLE and tx_done clears.
  - Level protocol: one byte per 0→1→0 cycle of tx_i[0]. Holding it high never resends.
  - Changes to tx_data_i after the latch are ignored until the next IDLE→SEND transition.
- Software TX sequence: write tx_data, write tx=1, poll until tx_done=1, write tx=0.
- RX FIFO:
  - Push on any clock edge with uart_rx_valid_i=1 and the FIFO not full.
  - Pop on a rising edge of clean_rx_i[0], detected against a registered copy. A pop when empty is ignored.
  - rx_valid = not empty. rx_data_o = head entry, registered output. A pushed byte is visible one cycle after its strobe.
  - Full and pop in the same cycle: both occur and no overrun is flagged. The count is unchanged and pointers wrap modulo RX_DEPTH.
  - Push while full with no pop: the byte is dropped and overrun sets.
  - Overrun is sticky. It clears on a rising edge of clean_rx_i[1]; a set in the same cycle wins.
  - Empty and push in the same cycle as a pop: the pop is ignored and the push lands.
- Reset mid-operation:
  - Mid-SEND: valid drops immediately and no handshake completes.
  - Occupied FIFO: entries are lost and rx_ready_o=0.
  - After reset is released, a tx_i[0] that is still high starts a new send. Software must clear tx first.
- Count width is log2(RX_DEPTH)+1 so full and empty are unambiguous.

Optional Feature:
- Macro: UART_MMIO_LOOPBACK_EN.
- Defined:
  - uart_tx_valid_o is tied 0 and uart_rx_valid_i is ignored.
  - Each byte that would be handed off is instead pushed into the RX FIFO in the cycle it leaves SEND. SEND→HOLD happens the cycle after entry; uart_tx_ready_i is ignored.
  - FIFO-full overrun rules still apply.
- Undefined: behaviour exactly as specified above.

Decomposition:
- Shared package uart_mmio_pkg holds:
  - tx_state_t enum (IDLE, SEND, HOLD).
  - Status bit index constants: RX_VALID_BIT=0, OVERRUN_BIT=1, TX_BUSY_BIT=2, TX_DONE_BIT=3.
  - Command bit indices: CMD_SEND_BIT=0, CMD_POP_BIT=0, CMD_CLR_OVR_BIT=1.
- One sub-module, rx_byte_fifo, parameterised by depth. It provides push/pop/full/empty/head and an overrun output.
- The top level holds the TX FSM, the edge detectors and status word assembly.

Test Plan:
- TX handshake: tx_data_i=0x41, tx_i=1, ready held 0 for 5 cycles, then 1.
  - Expect valid high from the cycle after tx_i, data 0x41, busy=1.
  - Expect HOLD with done=1, one byte only.
  - tx_i=0 → IDLE, status=0.
- Resend guard: hold tx_i=1 for 20 cycles after the handshake → exactly one valid&ready transfer.
- RX order: strobe bytes 0x10, 0x20, 0x30.
  - Expect rx_data_o=0x10 and rx_ready_o=0x1.
  - Three clean_rx bit0 pulses show 0x20, then 0x30, then empty with rx_data_o=0.
- Overrun: RX_DEPTH=4, push 5 bytes.
  - Expect rx_ready_o=0x3 and the fifth byte dropped.
  - A simultaneous push and pop while full leaves the count at 4 with no new overrun.
  - A clean_rx bit1 pulse clears overrun.
- Async reset mid-SEND and with 2 bytes queued: reset=0 between clock edges → all outputs 0 immediately, FIFO empty after release.
- With UART_MMIO_LOOPBACK_EN: send 0x5A → uart_tx_valid_o stays 0, rx_data_o=0x5A, rx_ready_o bit0=1.
